// File: rtl/weight_read_sequencer_if.sv
// weight_read_sequencer_if: activation stream, weight memory read port and MAC pair bus
interface weight_read_sequencer_if #(
  parameter int DATAWIDTH    = 16,
  parameter int ADDRESSWIDTH = 10
);
  logic                    start;
  logic                    clear;
  logic                    in_valid;
  logic [DATAWIDTH-1:0]    in_data;
  logic                    in_ready;
  logic                    ren;
  logic [ADDRESSWIDTH-1:0] radd;
  logic [DATAWIDTH-1:0]    wdata;
  logic                    mac_valid;
  logic [DATAWIDTH-1:0]    mac_x;
  logic [DATAWIDTH-1:0]    mac_w;
  logic                    mac_last;
  logic                    busy;
  logic                    done;
  modport slave (
    input  start, clear, in_valid, in_data, wdata,
    output in_ready, ren, radd, mac_valid, mac_x, mac_w, mac_last, busy, done
  );
  modport master (
    output start, clear, in_valid, in_data, wdata,
    input  in_ready, ren, radd, mac_valid, mac_x, mac_w, mac_last, busy, done
  );
endinterface

// File: rtl/weight_read_sequencer.sv
// weight_read_sequencer: issues one weight read per accepted activation and aligns the pair for the MAC
module weight_read_sequencer #(
  parameter int NUMWEIGHT    = 784,
  parameter int ADDRESSWIDTH = 10,
  parameter int DATAWIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  weight_read_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(NUMWEIGHT - 1);
  state_t                  state_q;
  logic [ADDRESSWIDTH-1:0] cnt_q;
  logic [DATAWIDTH-1:0]    x_q;
  logic                    v_q;
  logic                    last_q;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    accept;
  logic                    at_last;
  assign accept        = in_ready_q & bus.in_valid;
  assign at_last       = cnt_q == LAST_ADDR;
  assign bus.in_ready  = in_ready_q;
  assign bus.ren       = accept;
  assign bus.radd      = cnt_q;
  assign bus.mac_valid = v_q;
  assign bus.mac_x     = x_q;
  assign bus.mac_w     = bus.wdata;
  assign bus.mac_last  = v_q & last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  // Sequencer FSM; the activation is delayed one cycle to meet the memory's registered read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      v_q        <= 1'b0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      v_q        <= 1'b0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      v_q    <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (bus.start) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        RUN:
          if (accept) begin
            v_q    <= 1'b1;
            x_q    <= bus.in_data;
            last_q <= at_last;
            if (at_last) begin
              state_q    <= DRAIN;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + ADDRESSWIDTH'(1);
            end
          end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_weight_read_sequencer.sv
// tb_weight_read_sequencer: model-checked bench for the weight read sequencer
module tb_weight_read_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  weight_read_sequencer_if #(.DATAWIDTH(16), .ADDRESSWIDTH(10)) bus_a ();
  weight_read_sequencer_if #(.DATAWIDTH(16), .ADDRESSWIDTH(4))  bus_b ();
  weight_read_sequencer #(.NUMWEIGHT(4), .ADDRESSWIDTH(10), .DATAWIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  weight_read_sequencer #(.NUMWEIGHT(1), .ADDRESSWIDTH(4), .DATAWIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  logic [15:0] mem_a [4] = '{16'd5, 16'd6, 16'd7, 16'd8};
  // weight memories with one cycle registered read latency
  always @(posedge clk) begin
    if (bus_a.ren) bus_a.wdata <= (bus_a.radd < 10'd4) ? mem_a[bus_a.radd[1:0]] : 16'hDEAD;
    if (bus_b.ren) bus_b.wdata <= (bus_b.radd == 4'd0) ? 16'd3 : 16'hDEAD;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural model of instance A: evaluation running, accepts so far, cycles after the final accept
  logic        m_run = 1'b0;
  int          m_k = 0;
  int          m_tail = 0;
  logic        m_v = 1'b0;
  logic        m_last = 1'b0;
  logic [15:0] m_x = '0;
  logic [15:0] m_w = '0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || bus_a.clear) begin
      m_run = 1'b0; m_k = 0; m_tail = 0; m_v = 1'b0; m_last = 1'b0;
    end else begin
      m_v = m_run && bus_a.in_valid;
      if (m_v) begin
        m_x = bus_a.in_data;
        m_w = mem_a[m_k[1:0]];
        m_last = (m_k == 3);
      end
      if (m_tail != 0) m_tail = (m_tail == 1) ? 2 : 0;
      else if (m_run) begin
        if (m_v) begin
          m_k++;
          if (m_k == 4) begin m_run = 1'b0; m_k = 0; m_tail = 1; end
        end
      end else if (bus_a.start) begin
        m_run = 1'b1; m_k = 0;
      end
    end
  end
  // every-cycle comparison of instance A against the model
  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(bus_a.in_ready), 32'(m_run));
    chk("busy", 32'(bus_a.busy), 32'(m_run || m_tail != 0));
    chk("done", 32'(bus_a.done), 32'(m_tail == 2));
    chk("radd", 32'(bus_a.radd), 32'(m_k));
    chk("ren", 32'(bus_a.ren), 32'(m_run && bus_a.in_valid));
    chk("mac_valid", 32'(bus_a.mac_valid), 32'(m_v));
    chk("mac_last", 32'(bus_a.mac_last), 32'(m_v && m_last));
    if (m_v) begin
      chk("mac_x", 32'(bus_a.mac_x), 32'(m_x));
      chk("mac_w", 32'(bus_a.mac_w), 32'(m_w));
    end
    if (!rst_n) chk("mac_x_rst", 32'(bus_a.mac_x), 32'd0);
  end
  // observed pairs and done pulses of instance A, for literal checks per run
  logic [32:0] obs_q [$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus_a.mac_valid) begin
      obs_q.push_back({bus_a.mac_last, bus_a.mac_x, bus_a.mac_w});
      if (bus_a.mac_last) last_cyc = cyc;
    end
    if (bus_a.done) begin done_cnt++; done_cyc = cyc; end
  end
  task automatic check_run(input int npairs, input int ndone);
    chk("pair_count", 32'(obs_q.size()), 32'(npairs));
    for (int i = 0; i < npairs && i < obs_q.size(); i++) begin
      chk("pair_x", 32'(obs_q[i][31:16]), 32'(i + 1));
      chk("pair_w", 32'(obs_q[i][15:0]), 32'(i + 5));
      chk("pair_last", 32'(obs_q[i][32]), 32'(i == 3));
    end
    chk("done_count", 32'(done_cnt), 32'(ndone));
    if (ndone != 0) chk("done_latency", 32'(done_cyc - last_cyc), 32'd1);
    obs_q.delete();
    done_cnt = 0;
  endtask
  task automatic drive_a(input logic st, input logic cl, input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus_a.start = st; bus_a.clear = cl; bus_a.in_valid = v; bus_a.in_data = d;
  endtask
  task automatic run_a(input logic [15:0] pat, input int len, input logic hold_start);
    logic [15:0] d;
    d = 16'd1;
    drive_a(1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < len; i++)
      if (pat[i]) begin drive_a(hold_start, 1'b0, 1'b1, d); d++; end
      else drive_a(hold_start, 1'b0, 1'b0, 16'h00AA);
    if (hold_start) begin
      drive_a(1'b1, 1'b0, 1'b0, 16'd0);
      drive_a(1'b1, 1'b0, 1'b0, 16'd0);
    end
    drive_a(1'b0, 1'b0, 1'b0, 16'd0);
    repeat (4) @(posedge clk);
    check_run(4, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus_a.start = 1'b1; bus_a.clear = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_data = 16'h0011;
    bus_b.start = 1'b1; bus_b.clear = 1'b0; bus_b.in_valid = 1'b1; bus_b.in_data = 16'h0011;
    repeat (3) @(negedge clk);
    chk("rst_b_busy", 32'(bus_b.busy), 32'd0);
    chk("rst_b_ren", 32'(bus_b.ren), 32'd0);
    chk("rst_b_in_ready", 32'(bus_b.in_ready), 32'd0);
    drive_a(1'b0, 1'b0, 1'b0, 16'd0);
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check_run(0, 0);
    run_a(16'b1111, 4, 1'b0);
    run_a(16'b1011001, 7, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0, 16'd0);
    drive_a(1'b0, 1'b0, 1'b1, 16'd1);
    drive_a(1'b0, 1'b0, 1'b1, 16'd2);
    drive_a(1'b0, 1'b1, 1'b1, 16'd3);
    drive_a(1'b0, 1'b0, 1'b0, 16'd0);
    repeat (4) @(posedge clk);
    check_run(2, 0);
    run_a(16'b1111, 4, 1'b0);
    run_a(16'b1111, 4, 1'b1);
    drive_a(1'b1, 1'b1, 1'b0, 16'd0);
    drive_a(1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    chk("start_clear_idle", 32'(bus_a.busy), 32'd0);
    drive_a(1'b1, 1'b0, 1'b0, 16'd0);
    drive_a(1'b0, 1'b0, 1'b1, 16'd1);
    drive_a(1'b0, 1'b0, 1'b1, 16'd2);
    drive_a(1'b0, 1'b0, 1'b1, 16'd3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus_a.busy), 32'd0);
    chk("arst_in_ready", 32'(bus_a.in_ready), 32'd0);
    chk("arst_mac_valid", 32'(bus_a.mac_valid), 32'd0);
    chk("arst_radd", 32'(bus_a.radd), 32'd0);
    chk("arst_mac_x", 32'(bus_a.mac_x), 32'd0);
    drive_a(1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check_run(2, 0);
    @(posedge clk); #1;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0; bus_b.in_valid = 1'b1; bus_b.in_data = 16'd9;
    @(negedge clk);
    chk("b_ren", 32'(bus_b.ren), 32'd1);
    chk("b_radd", 32'(bus_b.radd), 32'd0);
    chk("b_in_ready", 32'(bus_b.in_ready), 32'd1);
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0; bus_b.in_data = 16'd0;
    @(negedge clk);
    chk("b_mac_valid", 32'(bus_b.mac_valid), 32'd1);
    chk("b_mac_x", 32'(bus_b.mac_x), 32'd9);
    chk("b_mac_w", 32'(bus_b.mac_w), 32'd3);
    chk("b_mac_last", 32'(bus_b.mac_last), 32'd1);
    chk("b_drain_in_ready", 32'(bus_b.in_ready), 32'd0);
    chk("b_drain_done", 32'(bus_b.done), 32'd0);
    @(negedge clk);
    chk("b_done", 32'(bus_b.done), 32'd1);
    chk("b_done_busy", 32'(bus_b.busy), 32'd1);
    chk("b_done_mac_valid", 32'(bus_b.mac_valid), 32'd0);
    @(negedge clk);
    chk("b_idle_busy", 32'(bus_b.busy), 32'd0);
    chk("b_idle_done", 32'(bus_b.done), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
